halfstrip_window_checker: RTL and testbench

- Sits directly downstream of the triad decoders, in the 40 MHz domain.
- Consumes the 32-bit halfstrips hit register they produce.
- After each injected pulse it opens a programmable bx window, ORs all halfstrip hits over that window, and compares the result against halfstrips_expect.
- Maintains a saturating error counter and the first-hit bx latency for serial readback. An optional hit-capture FIFO records every non-zero halfstrip word with its bx offset.

---
 rtl/halfstrip_window_checker.sv | 205 ++++++++++++++++++++
 tb/tb_halfstrip_window_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/halfstrip_window_checker.sv
// Halfstrip window checker: ORs triad-decoder halfstrip hits over a programmable bx window
// after each arm pulse, compares the result against halfstrips_expect, and counts mismatches.
// Optional hit-capture FIFO enabled by defining HS_CAPTURE_FIFO_EN.
module halfstrip_window_checker #(
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             arm,
    input  logic [7:0]       window_len,
    input  logic [31:0]      halfstrips,
    input  logic [31:0]      halfstrips_expect,
    input  logic             errcnt_rst,
    output logic             busy,
    output logic             done,
    output logic [31:0]      hs_accum,
    output logic             mismatch,
    output logic [CNT_W-1:0] halfstrips_errcnt,
    output logic             hit_seen,
    output logic [7:0]       first_hit_bx,
    input  logic             fifo_rd,
    output logic [39:0]      fifo_dout,
    output logic             fifo_empty,
    output logic             fifo_overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDOW  = 2'd1,
        COMPARE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       winLen_q, winLen_d;
    logic [7:0]       bx_q, bx_d;
    logic [31:0]      hsAccum_q, hsAccum_d;
    logic             mismatch_q, mismatch_d;
    logic             done_q, done_d;
    logic             hitSeen_q, hitSeen_d;
    logic [7:0]       firstHitBx_q, firstHitBx_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    logic armAccept;
    logic pushReq;

    assign armAccept = (state_q == IDLE) && arm;
    assign pushReq   = (state_q == WINDOW) && (halfstrips != 32'd0);

    always_comb begin
        state_d      = state_q;
        winLen_d     = winLen_q;
        bx_d         = bx_q;
        hsAccum_d    = hsAccum_q;
        mismatch_d   = mismatch_q;
        done_d       = done_q;
        hitSeen_d    = hitSeen_q;
        firstHitBx_d = firstHitBx_q;
        errCnt_d     = errCnt_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d      = WINDOW;
                    done_d       = 1'b0;
                    hsAccum_d    = 32'd0;
                    hitSeen_d    = 1'b0;
                    firstHitBx_d = 8'hFF;
                    bx_d         = 8'd0;
                    winLen_d     = (window_len == 8'd0) ? 8'd1 : window_len;
                end
            end
            WINDOW: begin
                hsAccum_d = hsAccum_q | halfstrips;
                if ((halfstrips != 32'd0) && !hitSeen_q) begin
                    firstHitBx_d = bx_q;
                    hitSeen_d    = 1'b1;
                end
                bx_d = bx_q + 8'd1;
                if (bx_q == (winLen_q - 8'd1)) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                mismatch_d = (hsAccum_q != halfstrips_expect);
                if (mismatch_d && (errCnt_q != {CNT_W{1'b1}})) begin
                    errCnt_d = errCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear beats a same-cycle increment.
        if (errcnt_rst) begin
            errCnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_q      <= IDLE;
            winLen_q     <= 8'd1;
            bx_q         <= 8'd0;
            hsAccum_q    <= 32'd0;
            mismatch_q   <= 1'b0;
            done_q       <= 1'b0;
            hitSeen_q    <= 1'b0;
            firstHitBx_q <= 8'hFF;
            errCnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            winLen_q     <= winLen_d;
            bx_q         <= bx_d;
            hsAccum_q    <= hsAccum_d;
            mismatch_q   <= mismatch_d;
            done_q       <= done_d;
            hitSeen_q    <= hitSeen_d;
            firstHitBx_q <= firstHitBx_d;
            errCnt_q     <= errCnt_d;
        end
    end

    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign hs_accum          = hsAccum_q;
    assign mismatch          = mismatch_q;
    assign halfstrips_errcnt = errCnt_q;
    assign hit_seen          = hitSeen_q;
    assign first_hit_bx      = firstHitBx_q;

`ifdef HS_CAPTURE_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [39:0]  fifoMem_q [FIFO_DEPTH];
    logic [PTR_W:0] wrPtr_q, wrPtr_d;
    logic [PTR_W:0] rdPtr_q, rdPtr_d;
    logic           overflow_q, overflow_d;
    logic           fifoFull;
    logic           fifoEmpty;
    logic           doPush;
    logic           doPop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                       (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign doPop     = fifo_rd && !fifoEmpty;
    assign doPush    = pushReq && (!fifoFull || doPop);

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        overflow_d = overflow_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + {{PTR_W{1'b0}}, 1'b1};
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + {{PTR_W{1'b0}}, 1'b1};
        end
        if (pushReq && !doPush) begin
            overflow_d = 1'b1;
        end
        if (armAccept) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            overflow_q <= overflow_d;
        end
    end

    // When full, the slot written here is the one being popped this same cycle.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem_q[wrPtr_q[PTR_W-1:0]] <= {bx_q, halfstrips};
        end
    end

    assign fifo_dout     = fifoMem_q[rdPtr_q[PTR_W-1:0]];
    assign fifo_empty    = fifoEmpty;
    assign fifo_overflow = overflow_q;
`else
    logic unusedFifoInputs;

    assign unusedFifoInputs = fifo_rd | pushReq | armAccept | (FIFO_DEPTH < 2);
    assign fifo_dout        = 40'd0;
    assign fifo_empty       = 1'b1;
    assign fifo_overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_halfstrip_window_checker.sv
// Randomized self-checking bench for halfstrip_window_checker with a window-level reference model.
// Builds with or without HS_CAPTURE_FIFO_EN.
module tb_halfstrip_window_checker;

    localparam int CNT_W      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             _reset;
    logic             arm;
    logic [7:0]       window_len;
    logic [31:0]      halfstrips;
    logic [31:0]      halfstrips_expect;
    logic             errcnt_rst;
    logic             busy;
    logic             done;
    logic [31:0]      hs_accum;
    logic             mismatch;
    logic [CNT_W-1:0] halfstrips_errcnt;
    logic             hit_seen;
    logic [7:0]       first_hit_bx;
    logic             fifo_rd;
    logic [39:0]      fifo_dout;
    logic             fifo_empty;
    logic             fifo_overflow;

    int total = 0;
    int bad   = 0;
    int modelErr = 0;
    logic [31:0] hits[$];
    logic [39:0] fifoModel[$];
    bit modelOvf;

    halfstrip_window_checker #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), ._reset(_reset), .arm(arm), .window_len(window_len),
        .halfstrips(halfstrips), .halfstrips_expect(halfstrips_expect),
        .errcnt_rst(errcnt_rst), .busy(busy), .done(done), .hs_accum(hs_accum),
        .mismatch(mismatch), .halfstrips_errcnt(halfstrips_errcnt), .hit_seen(hit_seen),
        .first_hit_bx(first_hit_bx), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;

    // Drives one full window from the current negedge using the words in hits[].
    task automatic runWindow(input logic [7:0] wlen, input logic [31:0] exp, input bit rstCnt, input bit armDuring);
        int eff;
        int first;
        logic [31:0] accum;
        logic [7:0] expFirst;
        bit mm;
        eff = (wlen == 8'd0) ? 1 : int'(wlen);
        accum = 32'd0;
        first = -1;
        fifoModel.delete();
        modelOvf = 1'b0;
        for (int i = 0; i < eff; i++) begin
            accum |= hits[i];
            if (hits[i] != 32'd0) begin
                if (first < 0) first = i;
                if (fifoModel.size() < FIFO_DEPTH) fifoModel.push_back({8'(i), hits[i]});
                else modelOvf = 1'b1;
            end
        end
        mm = (accum != exp);
        if (rstCnt) modelErr = 0;
        else if (mm && modelErr < CNT_MAX) modelErr++;
        expFirst = (first < 0) ? 8'hFF : 8'(first);

        arm = 1'b1; window_len = wlen; halfstrips = $urandom; halfstrips_expect = exp;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL win_busy_start got=%0h want=1", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL win_done_start got=%0h want=0", done); end
        total++; if (hs_accum !== 32'd0) begin bad++; $display("[TB] FAIL win_accum_clr got=%0h want=0", hs_accum); end
        total++; if (first_hit_bx !== 8'hFF) begin bad++; $display("[TB] FAIL win_first_clr got=%0h want=ff", first_hit_bx); end
`ifdef HS_CAPTURE_FIFO_EN
        total++; if (fifo_empty !== 1'b1 || fifo_overflow !== 1'b0) begin
            bad++; $display("[TB] FAIL win_fifo_flush got=%0h%0h want=10", fifo_empty, fifo_overflow); end
`endif
        for (int i = 0; i < eff; i++) begin
            arm = armDuring; window_len = 8'($urandom); halfstrips = hits[i];
            @(negedge clk);
        end
        total++; if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("[TB] FAIL win_pre_compare got=%0h%0h want=10", busy, done); end
        halfstrips = $urandom; errcnt_rst = rstCnt;
        @(negedge clk);
        arm = 1'b0; errcnt_rst = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL win_done got=%0h%0h want=10", done, busy); end
        total++; if (hs_accum !== accum) begin bad++; $display("[TB] FAIL win_accum got=%0h want=%0h", hs_accum, accum); end
        total++; if (mismatch !== mm) begin bad++; $display("[TB] FAIL win_mismatch got=%0h want=%0h", mismatch, mm); end
        total++; if (hit_seen !== (first >= 0)) begin bad++; $display("[TB] FAIL win_hit_seen got=%0h want=%0h", hit_seen, (first >= 0)); end
        total++; if (first_hit_bx !== expFirst) begin bad++; $display("[TB] FAIL win_first got=%0h want=%0h", first_hit_bx, expFirst); end
        total++; if (halfstrips_errcnt !== CNT_W'(modelErr)) begin
            bad++; $display("[TB] FAIL win_errcnt got=%0d want=%0d", halfstrips_errcnt, modelErr); end
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0 || hs_accum !== accum) begin
            bad++; $display("[TB] FAIL win_hold got=%0h%0h %0h want=10 %0h", done, busy, hs_accum, accum); end
`ifdef HS_CAPTURE_FIFO_EN
        total++; if (fifo_overflow !== modelOvf) begin bad++; $display("[TB] FAIL win_fifo_ovf got=%0h want=%0h", fifo_overflow, modelOvf); end
        for (int i = 0; i < fifoModel.size(); i++) begin
            total++; if (fifo_empty !== 1'b0 || fifo_dout !== fifoModel[i]) begin
                bad++; $display("[TB] FAIL win_fifo_entry%0d got=%0h/%0h want=0/%0h", i, fifo_empty, fifo_dout, fifoModel[i]); end
            fifo_rd = 1'b1;
            @(negedge clk);
            fifo_rd = 1'b0;
        end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("[TB] FAIL win_fifo_drained got=%0h want=1", fifo_empty); end
`else
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        total++; if (fifo_empty !== 1'b1 || fifo_overflow !== 1'b0 || fifo_dout !== 40'd0) begin
            bad++; $display("[TB] FAIL win_nofifo got=%0h%0h %0h want=10 0", fifo_empty, fifo_overflow, fifo_dout); end
`endif
    endtask

    task automatic test_reset();
        _reset = 1'b0; arm = 1'b1; halfstrips = $urandom; errcnt_rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_done got=%0h%0h want=00", busy, done); end
        total++; if (hs_accum !== 32'd0 || mismatch !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_accum_mm got=%0h %0h want=0 0", hs_accum, mismatch); end
        total++; if (halfstrips_errcnt !== '0) begin bad++; $display("[TB] FAIL rst_errcnt got=%0d want=0", halfstrips_errcnt); end
        total++; if (hit_seen !== 1'b0 || first_hit_bx !== 8'hFF) begin
            bad++; $display("[TB] FAIL rst_hit got=%0h %0h want=0 ff", hit_seen, first_hit_bx); end
        total++; if (fifo_empty !== 1'b1 || fifo_overflow !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_fifo got=%0h%0h want=10", fifo_empty, fifo_overflow); end
        _reset = 1'b1; arm = 1'b0; modelErr = 0;
        @(negedge clk);
    endtask

    task automatic test_match();
        hits.delete();
        hits.push_back(32'h0); hits.push_back(32'h10); hits.push_back(32'h0); hits.push_back(32'hE0);
        runWindow(8'd4, 32'h0000_00F0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        errcnt_rst = 1'b1;
        @(negedge clk);
        errcnt_rst = 1'b0; modelErr = 0;
        total++; if (halfstrips_errcnt !== '0) begin bad++; $display("[TB] FAIL sat_clear got=%0d want=0", halfstrips_errcnt); end
        for (int w = 0; w < 5; w++) begin
            hits.delete();
            for (int i = 0; i < 6; i++) hits.push_back(32'h0);
            runWindow(8'($urandom_range(1, 6)), 32'h1, (w == 4), 1'b0);
        end
    endtask

    task automatic test_len0_busy();
        hits.delete();
        hits.push_back(32'h4);
        runWindow(8'd0, 32'h4, 1'b0, 1'b1);
        runWindow(8'd0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        hits.delete();
        for (int i = 0; i < 8; i++) hits.push_back(32'h1 << i);
        arm = 1'b1; window_len = 8'd8; halfstrips = 32'h0;
        @(negedge clk);
        arm = 1'b0;
        for (int i = 0; i < 2; i++) begin
            halfstrips = hits[i];
            @(negedge clk);
        end
        _reset = 1'b0; halfstrips = hits[2];
        @(negedge clk);
        _reset = 1'b1; modelErr = 0;
        for (int i = 3; i < 8; i++) begin
            halfstrips = hits[i];
            @(negedge clk);
        end
        halfstrips = 32'h0; halfstrips_expect = 32'hFFFF_FFFF;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rmid_state got=%0h%0h want=00", busy, done); end
        total++; if (hs_accum !== 32'd0) begin bad++; $display("[TB] FAIL rmid_accum got=%0h want=0", hs_accum); end
        total++; if (halfstrips_errcnt !== '0) begin bad++; $display("[TB] FAIL rmid_errcnt got=%0d want=0", halfstrips_errcnt); end
        total++; if (hit_seen !== 1'b0 || first_hit_bx !== 8'hFF) begin
            bad++; $display("[TB] FAIL rmid_hit got=%0h %0h want=0 ff", hit_seen, first_hit_bx); end
    endtask

    task automatic test_random();
        for (int w = 0; w < 25; w++) begin
            int len;
            int eff;
            logic [31:0] orv;
            logic [31:0] exp;
            len = $urandom_range(0, 10);
            eff = (len == 0) ? 1 : len;
            hits.delete();
            orv = 32'h0;
            for (int i = 0; i < eff; i++) begin
                logic [31:0] wv;
                wv = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
                hits.push_back(wv);
                orv |= wv;
            end
            exp = ($urandom_range(0, 1) == 0) ? orv : $urandom;
            runWindow(8'(len), exp, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef HS_CAPTURE_FIFO_EN
    task automatic test_fifo();
        logic [31:0] orv;
        logic [39:0] want;
        for (int sc = 0; sc < 2; sc++) begin
            orv = 32'h0;
            for (int i = 0; i < 6; i++) orv |= (32'h100 + 32'(i));
            arm = 1'b1; window_len = 8'd6; halfstrips_expect = orv; halfstrips = 32'h0;
            @(negedge clk);
            arm = 1'b0;
            total++; if (fifo_overflow !== 1'b0 || fifo_empty !== 1'b1) begin
                bad++; $display("[TB] FAIL fifo_arm_clear sc%0d got=%0h%0h want=01", sc, fifo_overflow, fifo_empty); end
            for (int i = 0; i < 6; i++) begin
                halfstrips = 32'h100 + 32'(i);
                fifo_rd = (sc == 1) && (i >= 4);
                @(negedge clk);
            end
            halfstrips = 32'h0; fifo_rd = 1'b0;
            @(negedge clk);
            total++; if (done !== 1'b1 || mismatch !== 1'b0) begin
                bad++; $display("[TB] FAIL fifo_compare sc%0d got=%0h%0h want=10", sc, done, mismatch); end
            total++; if (fifo_overflow !== (sc == 0)) begin
                bad++; $display("[TB] FAIL fifo_ovf sc%0d got=%0h want=%0h", sc, fifo_overflow, (sc == 0)); end
            for (int i = 0; i < 4; i++) begin
                int bxv;
                bxv = (sc == 0) ? i : i + 2;
                want = {8'(bxv), 32'h100 + 32'(bxv)};
                total++; if (fifo_empty !== 1'b0 || fifo_dout !== want) begin
                    bad++; $display("[TB] FAIL fifo_pop sc%0d e%0d got=%0h/%0h want=0/%0h", sc, i, fifo_empty, fifo_dout, want); end
                fifo_rd = 1'b1;
                @(negedge clk);
                fifo_rd = 1'b0;
            end
            fifo_rd = 1'b1;
            @(negedge clk);
            fifo_rd = 1'b0;
            total++; if (fifo_empty !== 1'b1 || fifo_overflow !== (sc == 0)) begin
                bad++; $display("[TB] FAIL fifo_empty_pop sc%0d got=%0h%0h want=1%0h", sc, fifo_empty, fifo_overflow, (sc == 0)); end
        end
    endtask
`endif

    initial begin
        _reset = 1'b0; arm = 1'b0; window_len = 8'd0; halfstrips = 32'h0;
        halfstrips_expect = 32'h0; errcnt_rst = 1'b0; fifo_rd = 1'b0;
        @(negedge clk);
        test_reset();
        test_match();
        test_saturation();
        test_len0_busy();
        test_reset_mid();
`ifdef HS_CAPTURE_FIFO_EN
        test_fifo();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
